// File: rtl/bp_mem_latency_responder.sv
// Fixed-latency backing memory for the dcache/CCE harness: accepts one mem_cmd at a time,
// performs the read/write against a block array and returns mem_resp latency_p cycles later.
module bp_mem_latency_responder #(
    parameter int paddr_width_p   = 40,
    parameter int block_width_p   = 512,
    parameter int payload_width_p = 16,
    parameter int mem_els_p       = 64,
    parameter int latency_p       = 4,
    localparam int msg_width_lp   = 4 + paddr_width_p + 3 + payload_width_p + block_width_p
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [msg_width_lp-1:0] mem_cmd_i,
    input  logic                    mem_cmd_v_i,
    output logic                    mem_cmd_yumi_o,
    output logic [msg_width_lp-1:0] mem_resp_o,
    output logic                    mem_resp_v_o,
    input  logic                    mem_resp_ready_i
);

    localparam int addr_lsb_lp    = 4;
    localparam int size_lsb_lp    = addr_lsb_lp + paddr_width_p;
    localparam int payload_lsb_lp = size_lsb_lp + 3;
    localparam int data_lsb_lp    = payload_lsb_lp + payload_width_p;
    localparam int block_bytes_lp = block_width_p / 8;
    localparam int off_w_lp       = $clog2(block_bytes_lp);
    localparam int idx_w_lp       = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
    localparam int cnt_w_lp       = (latency_p > 1) ? $clog2(latency_p) : 1;

    // Handshake: a command moves when mem_cmd_v_i && mem_cmd_yumi_o (yumi only in IDLE);
    // a response moves when mem_resp_v_o && mem_resp_ready_i, and is held stable until then.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                    state_r, state_n;
    logic [cnt_w_lp-1:0]       cnt_r;
    logic [msg_width_lp-1:0]   resp_r;
    logic [block_width_p-1:0]  mem_r [mem_els_p];

    logic                      accept;
    logic [3:0]                cmd_type;
    logic [2:0]                cmd_size;
    logic [block_width_p-1:0]  cmd_data;
    logic [idx_w_lp-1:0]       cmd_idx;
    logic [off_w_lp-1:0]       raw_off, align_mask, cmd_off;
    logic [off_w_lp+2:0]       bit_off;
    logic [block_bytes_lp-1:0] sub_be, placed_be;
    logic [block_width_p-1:0]  sub_bits, be_bits;
    logic                      sub_ok, full_ok;
    logic [block_width_p-1:0]  rd_block, rd_data, wr_block;
    logic                      wr_en;

    assign accept   = mem_cmd_yumi_o;
    assign cmd_type = mem_cmd_i[3:0];
    assign cmd_size = mem_cmd_i[size_lsb_lp +: 3];
    assign cmd_data = mem_cmd_i[data_lsb_lp +: block_width_p];
    assign cmd_idx  = mem_cmd_i[addr_lsb_lp+off_w_lp +: idx_w_lp] & idx_w_lp'(mem_els_p - 1);
    assign raw_off  = mem_cmd_i[addr_lsb_lp +: off_w_lp];

    // Sub-block sizes: right-aligned byte enables and the offset bits forced to zero.
    always_comb begin
        sub_be     = '0;
        align_mask = '0;
        sub_ok     = 1'b1;
        full_ok    = 1'b0;
        case (cmd_size)
            3'd0: sub_be[0] = 1'b1;
            3'd1: begin sub_be[1:0] = '1; align_mask = off_w_lp'(1); end
            3'd2: begin sub_be[3:0] = '1; align_mask = off_w_lp'(3); end
            3'd3: begin sub_be[7:0] = '1; align_mask = off_w_lp'(7); end
            3'd6: begin sub_ok = 1'b0; full_ok = 1'b1; end
            default: sub_ok = 1'b0;
        endcase
    end

    assign cmd_off   = raw_off & ~align_mask;
    assign bit_off   = {cmd_off, 3'b000};
    assign placed_be = sub_be << cmd_off;

    always_comb begin
        sub_bits = '0;
        be_bits  = '0;
        for (int b = 0; b < block_bytes_lp; b++) begin
            sub_bits[8*b +: 8] = {8{sub_be[b]}};
            be_bits[8*b +: 8]  = {8{placed_be[b]}};
        end
    end

    assign rd_block = mem_r[cmd_idx];

    always_comb begin
        rd_data = '0;
        case (cmd_type)
            4'd0: rd_data = rd_block;
            4'd2: begin
                if (full_ok)     rd_data = rd_block;
                else if (sub_ok) rd_data = (rd_block >> bit_off) & sub_bits;
            end
            default: rd_data = '0;
        endcase
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_block = rd_block;
        if (accept) begin
            case (cmd_type)
                4'd1: begin wr_en = 1'b1; wr_block = cmd_data; end
                4'd3: begin
                    if (full_ok) begin
                        wr_en    = 1'b1;
                        wr_block = cmd_data;
                    end else if (sub_ok) begin
                        wr_en    = 1'b1;
                        wr_block = (rd_block & ~be_bits) | ((cmd_data << bit_off) & be_bits);
                    end
                end
                default: wr_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < mem_els_p; i++) mem_r[i] <= '0;
        end else if (wr_en) begin
            mem_r[cmd_idx] <= wr_block;
        end
    end

    // The response is built at accept so later writes cannot disturb it.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            resp_r <= '0;
            cnt_r  <= '0;
        end else begin
            if (accept) begin
                resp_r <= {rd_data, mem_cmd_i[data_lsb_lp-1:0]};
                cnt_r  <= cnt_w_lp'(latency_p - 1);
            end else if (state_r == WAIT && cnt_r != '0) begin
                cnt_r <= cnt_r - cnt_w_lp'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= IDLE;
        else            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: if (mem_cmd_v_i && reset_n_i) state_n = (latency_p == 1) ? RESP : WAIT;
            WAIT: if (cnt_r <= cnt_w_lp'(1)) state_n = RESP;
            RESP: if (mem_resp_ready_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        mem_cmd_yumi_o = 1'b0;
        mem_resp_v_o   = 1'b0;
        case (state_r)
            IDLE:    mem_cmd_yumi_o = mem_cmd_v_i & reset_n_i;
            RESP:    mem_resp_v_o = 1'b1;
            default: ;
        endcase
    end

    assign mem_resp_o = resp_r;

endmodule

// File: tb/tb_bp_mem_latency_responder.sv
// Bench for bp_mem_latency_responder: byte-level memory model feeds an expected-response queue,
// scenario tasks drive commands and compare responses, latency 1/7 instances check timing.
module tb_bp_mem_latency_responder;
  localparam int MW   = 4 + 40 + 3 + 16 + 512;
  localparam int SLSB = 44;
  localparam int PLSB = 47;
  localparam int DLSB = 63;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [MW-1:0] cmd = '0, resp;
  logic cmd_v = 1'b0, yumi, resp_v, resp_ready = 1'b0;
  logic [MW-1:0] cmd1 = '0, resp1, cmd7 = '0, resp7;
  logic v1 = 1'b0, yumi1, rv1, rdy1 = 1'b0;
  logic v7 = 1'b0, yumi7, rv7, rdy7 = 1'b0;

  logic [MW-1:0]  exp_q[$];
  logic [511:0]   mem_m [64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bp_mem_latency_responder dut (
    .clk_i(clk), .reset_n_i(rst_n), .mem_cmd_i(cmd), .mem_cmd_v_i(cmd_v),
    .mem_cmd_yumi_o(yumi), .mem_resp_o(resp), .mem_resp_v_o(resp_v), .mem_resp_ready_i(resp_ready));

  bp_mem_latency_responder #(.mem_els_p(4), .latency_p(1)) dut_l1 (
    .clk_i(clk), .reset_n_i(rst_n), .mem_cmd_i(cmd1), .mem_cmd_v_i(v1),
    .mem_cmd_yumi_o(yumi1), .mem_resp_o(resp1), .mem_resp_v_o(rv1), .mem_resp_ready_i(rdy1));

  bp_mem_latency_responder #(.mem_els_p(4), .latency_p(7)) dut_l7 (
    .clk_i(clk), .reset_n_i(rst_n), .mem_cmd_i(cmd7), .mem_cmd_v_i(v7),
    .mem_cmd_yumi_o(yumi7), .mem_resp_o(resp7), .mem_resp_v_o(rv7), .mem_resp_ready_i(rdy7));

  function automatic logic [MW-1:0] mk(input logic [3:0] t, input logic [39:0] a,
                                       input logic [2:0] s, input logic [15:0] p,
                                       input logic [511:0] d);
    return {d, p, s, a, t};
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) mem_m[i] = '0;
  endfunction

  // Behavioural memory: executes one command and returns the response it should produce.
  function automatic logic [MW-1:0] model_exec(input logic [MW-1:0] c);
    logic [3:0]   t;
    logic [39:0]  a;
    logic [2:0]   s;
    logic [511:0] d, rd;
    int idx, off, nb;
    t = c[3:0];
    a = c[4 +: 40];
    s = c[SLSB +: 3];
    d = c[DLSB +: 512];
    idx = int'(a[11:6]);
    off = int'(a[5:0]);
    rd = '0;
    case (s)
      3'd0: nb = 1;
      3'd1: nb = 2;
      3'd2: nb = 4;
      3'd3: nb = 8;
      3'd6: nb = 64;
      default: nb = 0;
    endcase
    if (nb >= 1 && nb <= 8) off = (off / nb) * nb;
    case (t)
      4'd0: rd = mem_m[idx];
      4'd1: mem_m[idx] = d;
      4'd2: begin
        if (nb == 64) rd = mem_m[idx];
        else for (int b = 0; b < nb; b++) rd[8*b +: 8] = mem_m[idx][8*(off+b) +: 8];
      end
      4'd3: begin
        if (nb == 64) mem_m[idx] = d;
        else for (int b = 0; b < nb; b++) mem_m[idx][8*(off+b) +: 8] = d[8*b +: 8];
      end
      default: ;
    endcase
    return {rd, c[DLSB-1:0]};
  endfunction

  function automatic logic [MW-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic issue(input logic [MW-1:0] c, output int acc_cyc, output bit ok);
    ok = 1'b0;
    acc_cyc = -1;
    @(negedge clk);
    cmd = c;
    cmd_v = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      if (yumi === 1'b1) begin ok = 1'b1; acc_cyc = cyc; end
      else @(negedge clk);
    end
    if (ok) begin
      exp_q.push_back(model_exec(c));
      @(posedge clk);
      #1;
    end
    cmd_v = 1'b0;
  endtask

  task automatic collect(input int stall, output logic [MW-1:0] r, output int rv_cyc, output bit ok);
    ok = 1'b0;
    rv_cyc = -1;
    r = '0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (resp_v === 1'b1) begin ok = 1'b1; rv_cyc = cyc; r = resp; end
    end
    if (ok) begin
      repeat (stall) @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
    end
  endtask

  task automatic xact(input logic [MW-1:0] c, input int stall, output logic [MW-1:0] r,
                      output int lat, output bit ok);
    int ta, tr;
    bit ok1, ok2;
    issue(c, ta, ok1);
    r = '0;
    tr = 0;
    ok2 = 1'b0;
    if (ok1) collect(stall, r, tr, ok2);
    ok = ok1 && ok2;
    lat = tr - ta;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd = mk(4'd0, 40'h80, 3'd6, 16'h5555, '0);
    cmd_v = 1'b1;
    v1 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (yumi !== 1'b0 || yumi1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_yumi: got %b/%b want 0/0", yumi, yumi1);
    end
    n_checks++;
    if (resp_v !== 1'b0) begin n_fail++; $display("FAIL reset_resp_v: got %b want 0", resp_v); end
    n_checks++;
    if (resp !== '0) begin n_fail++; $display("FAIL reset_resp: got %h want 0", resp); end
    cmd_v = 1'b0;
    v1 = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cleared_read();
    logic [MW-1:0] r, e;
    int lat;
    bit ok;
    xact(mk(4'd0, 40'h80, 3'd6, 16'h1234, rand_blk()), 0, r, lat, ok);
    e = pop_exp();
    n_checks++;
    if (!ok || r !== e) begin n_fail++; $display("FAIL cleared_read: got %h want %h", r, e); end
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL cleared_read_latency: got %0d want 4", lat); end
    n_checks++;
    if (r[DLSB +: 512] !== '0 || r[PLSB +: 16] !== 16'h1234 || r[4 +: 40] !== 40'h80) begin
      n_fail++; $display("FAIL cleared_read_fields: data %h payload %h addr %h", r[DLSB +: 512],
                         r[PLSB +: 16], r[4 +: 40]);
    end
  endtask

  task automatic test_cached_wr_rd();
    logic [MW-1:0] r, e;
    logic [511:0] pat;
    int lat;
    bit ok;
    pat = {8{64'h0123456789ABCDEF}};
    xact(mk(4'd1, 40'h1000, 3'd6, 16'h0001, pat), 1, r, lat, ok);
    e = pop_exp();
    n_checks++;
    if (!ok || r !== e) begin n_fail++; $display("FAIL cached_write_resp: got %h want %h", r, e); end
    xact(mk(4'd0, 40'h1000, 3'd6, 16'h0002, '0), 0, r, lat, ok);
    e = pop_exp();
    n_checks++;
    if (!ok || r !== e || r[DLSB +: 512] !== pat) begin
      n_fail++; $display("FAIL cached_read: got %h want %h", r, e);
    end
    xact(mk(4'd0, 40'h2000, 3'd6, 16'h0003, '0), 0, r, lat, ok);
    e = pop_exp();
    n_checks++;
    if (!ok || r !== e || r[DLSB +: 512] !== pat) begin
      n_fail++; $display("FAIL cached_read_alias: got %h want %h", r, e);
    end
  endtask

  task automatic test_uncached();
    logic [MW-1:0] r, e;
    logic [511:0] blk;
    int lat;
    bit ok;
    xact(mk(4'd3, 40'h204, 3'd2, 16'h0010, 512'hDEADBEEF), 0, r, lat, ok);
    e = pop_exp();
    n_checks++;
    if (!ok || r !== e) begin n_fail++; $display("FAIL uc_write_resp: got %h want %h", r, e); end
    xact(mk(4'd2, 40'h200, 3'd3, 16'h0011, '1), 0, r, lat, ok);
    e = pop_exp();
    n_checks++;
    if (!ok || r !== e || r[DLSB +: 512] !== 512'hDEADBEEF_00000000) begin
      n_fail++; $display("FAIL uc_read8: got %h want %h", r[DLSB +: 512], e[DLSB +: 512]);
    end
    blk = '0;
    blk[63:32] = 32'hDEADBEEF;
    xact(mk(4'd0, 40'h200, 3'd6, 16'h0012, '0), 0, r, lat, ok);
    e = pop_exp();
    n_checks++;
    if (!ok || r !== e || r[DLSB +: 512] !== blk) begin
      n_fail++; $display("FAIL uc_cached_view: got %h want %h", r[DLSB +: 512], blk);
    end
    xact(mk(4'd2, 40'h205, 3'd1, 16'h0013, '0), 0, r, lat, ok);
    e = pop_exp();
    n_checks++;
    if (!ok || r !== e || r[DLSB +: 512] !== 512'hBEEF) begin
      n_fail++; $display("FAIL uc_read2_misaligned: got %h want beef", r[DLSB +: 512]);
    end
    xact(mk(4'd3, 40'h200, 3'd4, 16'h0014, '1), 0, r, lat, ok);
    e = pop_exp();
    n_checks++;
    if (!ok || r !== e) begin n_fail++; $display("FAIL uc_bad_size_resp: got %h want %h", r, e); end
    xact(mk(4'd0, 40'h200, 3'd6, 16'h0015, '0), 0, r, lat, ok);
    e = pop_exp();
    n_checks++;
    if (!ok || r !== e || r[DLSB +: 512] !== blk) begin
      n_fail++; $display("FAIL uc_bad_size_nowrite: got %h want %h", r[DLSB +: 512], blk);
    end
  endtask

  task automatic test_backpressure();
    logic [MW-1:0] a, b, r0, r, e;
    int ta, tv, tr;
    bit ok, seen;
    a = mk(4'd0, 40'h1000, 3'd6, 16'hAAAA, '0);
    b = mk(4'd2, 40'h204, 3'd2, 16'hBBBB, '0);
    issue(a, ta, ok);
    seen = 1'b0;
    tv = -1;
    r0 = '0;
    for (int i = 0; i < 20 && ok && !seen; i++) begin
      @(negedge clk);
      #1;
      if (resp_v === 1'b1) begin seen = 1'b1; tv = cyc; r0 = resp; end
    end
    n_checks++;
    if (!ok || !seen || tv != ta + 4) begin
      n_fail++; $display("FAIL bp_first_valid: accept %0d valid %0d want +4", ta, tv);
    end
    e = pop_exp();
    n_checks++;
    if (r0 !== e) begin n_fail++; $display("FAIL bp_resp: got %h want %h", r0, e); end
    cmd = b;
    cmd_v = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (resp_v !== 1'b1 || resp !== r0 || yumi !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold cycle %0d: v %b yumi %b resp %h", i, resp_v, yumi, resp);
      end
    end
    resp_ready = 1'b1;
    #1;
    n_checks++;
    if (yumi !== 1'b0 || resp_v !== 1'b1) begin
      n_fail++; $display("FAIL bp_no_turnaround: yumi %b v %b want 0 1", yumi, resp_v);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (yumi !== 1'b1) begin n_fail++; $display("FAIL bp_second_accept: yumi %b want 1", yumi); end
    if (yumi === 1'b1) exp_q.push_back(model_exec(b));
    @(posedge clk);
    #1;
    cmd_v = 1'b0;
    collect(0, r, tr, ok);
    e = pop_exp();
    n_checks++;
    if (!ok || r !== e || r[DLSB +: 512] !== 512'hDEADBEEF) begin
      n_fail++; $display("FAIL bp_second_resp: got %h want %h", r, e);
    end
  endtask

  task automatic test_latency();
    logic [MW-1:0] c;
    int t, tv;
    bit seen;
    c = mk(4'd0, 40'h40, 3'd6, 16'h0101, rand_blk());
    @(negedge clk);
    cmd1 = c;
    v1 = 1'b1;
    rdy1 = 1'b1;
    #1;
    t = cyc;
    n_checks++;
    if (yumi1 !== 1'b1) begin n_fail++; $display("FAIL lat1_accept: yumi %b want 1", yumi1); end
    @(posedge clk);
    #1;
    v1 = 1'b0;
    seen = 1'b0;
    tv = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (i > 0) @(negedge clk);
      else @(negedge clk);
      #1;
      if (rv1 === 1'b1) begin seen = 1'b1; tv = cyc; end
    end
    n_checks++;
    if (!seen || tv != t + 1 || resp1 !== {512'd0, c[DLSB-1:0]}) begin
      n_fail++; $display("FAIL lat1_valid: accept %0d valid %0d resp %h", t, tv, resp1);
    end
    @(posedge clk);
    #1;
    rdy1 = 1'b0;

    c = mk(4'd0, 40'hC0, 3'd6, 16'h0707, rand_blk());
    @(negedge clk);
    cmd7 = c;
    v7 = 1'b1;
    rdy7 = 1'b1;
    #1;
    t = cyc;
    n_checks++;
    if (yumi7 !== 1'b1) begin n_fail++; $display("FAIL lat7_accept: yumi %b want 1", yumi7); end
    @(posedge clk);
    #1;
    v7 = 1'b0;
    seen = 1'b0;
    tv = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (rv7 === 1'b1) begin seen = 1'b1; tv = cyc; end
    end
    n_checks++;
    if (!seen || tv != t + 7 || resp7 !== {512'd0, c[DLSB-1:0]}) begin
      n_fail++; $display("FAIL lat7_valid: accept %0d valid %0d resp %h", t, tv, resp7);
    end
    @(posedge clk);
    #1;
    rdy7 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [MW-1:0] r, e;
    int lat, ta;
    bit ok, stray, seen;
    xact(mk(4'd1, 40'h3040, 3'd6, 16'h0030, rand_blk()), 0, r, lat, ok);
    e = pop_exp();
    n_checks++;
    if (!ok || r !== e) begin n_fail++; $display("FAIL rm_write: got %h want %h", r, e); end
    issue(mk(4'd0, 40'h3040, 3'd6, 16'h0031, '0), ta, ok);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (resp_v !== 1'b0 || resp !== '0) begin
      n_fail++; $display("FAIL rm_wait_reset: v %b resp %h want 0", resp_v, resp);
    end
    exp_q.delete();
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (resp_v === 1'b1) stray = 1'b1;
    end
    resp_ready = 1'b0;
    n_checks++;
    if (stray) begin n_fail++; $display("FAIL rm_no_resp: got stray response want none"); end
    xact(mk(4'd0, 40'h3040, 3'd6, 16'h0032, '0), 0, r, lat, ok);
    e = pop_exp();
    n_checks++;
    if (!ok || r !== e || r[DLSB +: 512] !== '0) begin
      n_fail++; $display("FAIL rm_cleared: got %h want %h", r[DLSB +: 512], e[DLSB +: 512]);
    end
    issue(mk(4'd0, 40'h80, 3'd6, 16'h0033, '0), ta, ok);
    seen = 1'b0;
    for (int i = 0; i < 20 && ok && !seen; i++) begin
      @(negedge clk);
      #1;
      if (resp_v === 1'b1) seen = 1'b1;
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (!seen || resp_v !== 1'b0) begin
      n_fail++; $display("FAIL rm_resp_reset: seen %b v %b want 1 0", seen, resp_v);
    end
    exp_q.delete();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [MW-1:0] r, e;
    logic [2:0] sizes [6];
    int lat, bad;
    bit ok;
    sizes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd4};
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      xact(mk(4'($urandom_range(0, 3)), 40'($urandom_range(0, 8191)),
              sizes[$urandom_range(0, 5)], 16'($urandom), rand_blk()),
           $urandom_range(0, 3), r, lat, ok);
      e = pop_exp();
      n_checks++;
      if (!ok || r !== e || lat != 4) begin
        n_fail++; bad++;
        if (bad < 4) $display("FAIL random_%0d: lat %0d got %h want %h", n, lat, r, e);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_cleared_read();
    test_cached_wr_rd();
    test_uncached();
    test_backpressure();
    test_latency();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
